// File: rtl/uparc_intr_ctrl_if.sv
// Register slave port of the interrupt controller: address, strobes, data and completion.
// The master drives the access; the controller (slave) returns registered data and a
// one-cycle completion pulse.
interface uparc_intr_ctrl_if;
    logic [1:0]  i_reg_addr;
    logic        i_reg_rd;
    logic        i_reg_wr;
    logic [31:0] i_reg_wdata;
    logic [31:0] o_reg_rdata;
    logic        o_reg_rdy;

    modport master (
        output i_reg_addr,
        output i_reg_rd,
        output i_reg_wr,
        output i_reg_wdata,
        input  o_reg_rdata,
        input  o_reg_rdy
    );

    modport slave (
        input  i_reg_addr,
        input  i_reg_rd,
        input  i_reg_wr,
        input  i_reg_wdata,
        output o_reg_rdata,
        output o_reg_rdy
    );
endinterface

// File: rtl/uparc_intr_ctrl.sv
// Interrupt controller in front of the COP0 exception/interrupt unit.
// Synchronises NLINES external lines, captures them into PEND, masks them, picks the
// lowest-numbered active line and presents one request at a time on o_intr with an
// ack / EOI handshake. Registers: 0 PEND, 1 MASK, 2 ID/EOI, 3 MODE.
// Optional macro UPARC_INTC_EDGE_EN: builds per-line edge capture, the MODE register
// and PEND write-1-to-clear. Without it every line is level-sensitive.
module uparc_intr_ctrl #(
    parameter int unsigned NLINES      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NLINES-1:0] i_irq,
    input  logic              i_intr_ack,
    output logic              o_intr,
    output logic [4:0]        o_intr_id,
    uparc_intr_ctrl_if.slave  reg_bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_ID   = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    logic [NLINES-1:0] sync_q [SYNC_STAGES];
    logic [NLINES-1:0] sync;
    logic [NLINES-1:0] pend_q;
    logic [NLINES-1:0] pend_d;
    logic [NLINES-1:0] mask_q;
    logic [NLINES-1:0] mode_rd;
    logic [NLINES-1:0] mp;
    logic [31:0]       mp_ext;
    logic [4:0]        sel;
    logic              cur_hit;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [4:0]        cur_id_q;
    logic [4:0]        cur_id_d;
    logic              intr_q;
    logic              intr_d;

    logic [31:0]       rd_val;
    logic [31:0]       rdata_q;
    logic              rdy_q;

    logic              wr_mask;
    logic              eoi;

    assign wr_mask = reg_bus.i_reg_wr && (reg_bus.i_reg_addr == ADDR_MASK);
    assign eoi     = reg_bus.i_reg_wr && (reg_bus.i_reg_addr == ADDR_ID);

    // Synchroniser chain: stage 0 samples the asynchronous lines.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef UPARC_INTC_EDGE_EN
    logic [NLINES-1:0] sync_prev_q;
    logic [NLINES-1:0] mode_q;
    logic [NLINES-1:0] w1c;
    logic              wr_mode;

    assign wr_mode = reg_bus.i_reg_wr && (reg_bus.i_reg_addr == ADDR_MODE);
    assign w1c     = (reg_bus.i_reg_wr && (reg_bus.i_reg_addr == ADDR_PEND)) ?
                     reg_bus.i_reg_wdata[NLINES-1:0] : '0;

    // Previous synchronised value and per-line mode select.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_prev_q <= '0;
            mode_q      <= '0;
        end else begin
            sync_prev_q <= sync;
            if (wr_mode) begin
                mode_q <= reg_bus.i_reg_wdata[NLINES-1:0];
            end
        end
    end

    // Level lines follow sync; edge lines latch a rising edge, which beats a same-cycle W1C.
    always_comb begin
        pend_d = (~mode_q & sync) |
                 (mode_q & ((pend_q & ~w1c) | (sync & ~sync_prev_q)));
    end

    assign mode_rd = mode_q;
`else
    // Every line is level-sensitive: pending simply mirrors the synchronised input.
    always_comb begin
        pend_d = sync;
    end

    assign mode_rd = '0;
`endif

    // Pending and mask registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= reg_bus.i_reg_wdata[NLINES-1:0];
            end
        end
    end

    assign mp = pend_q & mask_q;

    // Fixed priority: the lowest set index of the masked pending vector wins.
    always_comb begin
        sel    = 5'd0;
        mp_ext = '0;
        mp_ext[NLINES-1:0] = mp;
        for (int i = int'(NLINES) - 1; i >= 0; i--) begin
            if (mp[i]) begin
                sel = 5'(i);
            end
        end
    end

    assign cur_hit = mp_ext[cur_id_q];

    // Request FSM next state: raise, wait for ack (tracking higher priority), wait for EOI.
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        intr_d   = intr_q;
        case (state_q)
            ST_IDLE: begin
                if (mp != '0) begin
                    state_d  = ST_ASSERT;
                    cur_id_d = sel;
                    intr_d   = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (i_intr_ack) begin
                    state_d = ST_SERVICE;
                    intr_d  = 1'b0;
                end else if (!cur_hit) begin
                    state_d = ST_IDLE;
                    intr_d  = 1'b0;
                end else begin
                    cur_id_d = sel;
                end
            end
            ST_SERVICE: begin
                intr_d = 1'b0;
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                intr_d  = 1'b0;
            end
        endcase
    end

    // Request FSM state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            cur_id_q <= 5'd0;
            intr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            intr_q   <= intr_d;
        end
    end

    assign o_intr    = intr_q;
    assign o_intr_id = (state_q != ST_IDLE) ? cur_id_q : 5'd0;

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_val = '0;
        case (reg_bus.i_reg_addr)
            ADDR_PEND: rd_val[NLINES-1:0] = pend_q;
            ADDR_MASK: rd_val[NLINES-1:0] = mask_q;
            ADDR_ID:   rd_val = {(state_q != ST_IDLE), 26'b0, o_intr_id};
            ADDR_MODE: rd_val[NLINES-1:0] = mode_rd;
            default:   rd_val = '0;
        endcase
    end

    // Registered read data and one-cycle completion pulse for every access.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdata_q <= reg_bus.i_reg_rd ? rd_val : 32'd0;
            rdy_q   <= reg_bus.i_reg_rd || reg_bus.i_reg_wr;
        end
    end

    assign reg_bus.o_reg_rdata = rdata_q;
    assign reg_bus.o_reg_rdy   = rdy_q;

endmodule

// File: doc/uparc_intr_ctrl.md
Name: uparc_intr_ctrl

Overview:
Interrupt controller that sits in front of the COP0 exceptions/interrupts unit. It aggregates NLINES external interrupt sources into the single CPU interrupt request o_intr. It provides synchronisation, per-line masking, pending capture, fixed-priority selection and an acknowledge/end-of-interrupt (EOI) handshake, so one request is presented to the core at a time. Software accesses it through a small 4-register slave port.

Parameters:
NLINES, 8, number of interrupt lines (1..32)
SYNC_STAGES, 2, synchroniser depth on i_irq (>=2)

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
i_irq  in  NLINES  external interrupt lines, asynchronous, active-high
i_intr_ack  in  1  single-cycle pulse from core: hardware interrupt taken
o_intr  out  1  interrupt request to COP0 EIU, registered
o_intr_id  out  5  ID of the request currently presented or in service
i_reg_addr  in  2  register select: 0 PEND, 1 MASK, 2 ID/EOI, 3 MODE
i_reg_rd  in  1  read strobe
i_reg_wr  in  1  write strobe
i_reg_wdata  in  32  write data
o_reg_rdata  out  32  read data, valid when o_reg_rdy=1
o_reg_rdy  out  1  access complete, one-cycle pulse

Behaviour:
- Reset: all synchroniser flops, pend and mask are 0. State is IDLE. Outputs o_intr=0, o_intr_id=0, o_reg_rdata=0, o_reg_rdy=0.
- Synchroniser: each i_irq bit passes through SYNC_STAGES flops, giving sync[i].
- Pending register pend[NLINES-1:0] is updated every cycle.
  - Level line: pend[i] <= sync[i].
  - Edge line: pend[i] set on a 0->1 transition of sync[i]. Cleared only by writing 1 to that bit of PEND. A set and a clear in the same cycle: set wins.
- Masked pending: mp = pend & mask.
- Selection: lowest set index of mp wins (bit 0 has highest priority). The selected index is sel. Bits at or above NLINES read as 0.
- Request FSM, states IDLE, ASSERT, SERVICE:
  - IDLE: if mp != 0, go to ASSERT; latch cur_id <= sel; o_intr <= 1.
  - ASSERT: if i_intr_ack, go to SERVICE; o_intr <= 0.
  - ASSERT, without ack: if mp[cur_id] drops to 0 (line withdrawn or masked), go to IDLE; o_intr <= 0. If a higher-priority line arrives, cur_id is re-latched to sel; there is no preemption once the request is in SERVICE.
  - SERVICE: an EOI (write to address 2, any data) goes to IDLE. No new request is raised before the EOI.
  - i_intr_ack outside ASSERT is ignored. EOI outside SERVICE is ignored.
- o_intr_id = cur_id in ASSERT and SERVICE, 0 in IDLE.
- Latency: an i_irq rising edge that is stable before clock edge 1 gives o_intr=1 after edge SYNC_STAGES+2 (4 edges at the default). The next request can be raised 1 cycle after EOI, at the earliest.
- Register port:
  - One access per cycle. o_reg_rdy pulses exactly 1 cycle after any rd or wr strobe.
  - Read data is registered. If rd and wr occur together, the write takes effect and rdata returns the value before the write.
  - PEND: reads pend. Write is W1C, edge lines only.
  - MASK: read/write, NLINES LSBs; upper bits read 0.
  - ID: read gives {valid, 26'b0, cur_id}, where valid = (state != IDLE). Write = EOI.
  - MODE: 1 = edge, 0 = level per line. Reset value 0.
- A MODE change takes effect the next cycle. Pend bits of lines switched to level follow sync from then on.
- Reset asserted mid-operation clears everything immediately (asynchronously). o_intr drops with no ack required.

Optional Feature:
UPARC_INTC_EDGE_EN
- Defined: edge detection logic, a MODE register and PEND W1C are implemented as described.
- Undefined: all lines are level-sensitive. MODE reads 0 and writes to it are ignored. PEND writes have no effect. The edge-detect flops are not built.

Test Plan:
- MASK=0x01, i_irq[0] held high -> o_intr=1 at edge 4; o_intr_id=0; ID reads 0x80000000.
- In ASSERT with id 0, pulse i_intr_ack -> o_intr=0 next cycle. EOI write -> state IDLE. Line still high -> o_intr=1 again 1 cycle later.
- MASK=0xFF, i_irq=0x28 -> o_intr_id=3; ack, then EOI with bit 3 dropped -> next request has o_intr_id=5.
- MODE=0x04 (edge), 2-cycle pulse on i_irq[2] -> PEND=0x04 held after the pulse. W1C write 0x04 in the same cycle as a new edge -> PEND stays 0x04.
- In ASSERT, clear MASK -> o_intr=0 one cycle later, state IDLE, no ack needed. Assert nrst in SERVICE -> all outputs 0 and MASK reads 0.
- With UPARC_INTC_EDGE_EN undefined: write MODE=0xFF -> reads 0. A pulse on i_irq[1] with MASK=0x02 -> PEND bit 1 tracks the synchronised line only.
